// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, reset defaults,
// fetch FSM states and the IF/ID bundle.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES   = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    BUF_FULL,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction that returns
// while Decode is stalled.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_data,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_clear || i_drain) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem handshake FSM and
// the IF/ID pipeline register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_F,
  input  logic            stall_D,
  input  logic            pc_src_D,
  input  logic [XLEN-1:0] pc_branch_D,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_F,
  output logic [XLEN-1:0] instr_D,
  output logic [XLEN-1:0] pc_plus4_D,
  output logic            valid_D
);

  fetch_state_e    r_state, w_nxt;
  logic [XLEN-1:0] r_pc, r_old, w_pc_nxt, w_pc_inc;
  logic            r_req, w_req_nxt;
  if_id_t          r_ifid, w_ifid_nxt;
  logic            w_redirect, w_ack;
  logic            w_ld_mem, w_ld_buf, w_buf_ld;
  logic            w_buf_vld;
  logic [XLEN-1:0] w_buf_data, w_buf_pc;

  assign w_redirect = pc_src_D & ~stall_D;
  assign w_ack      = imem_ack & r_req;
  assign w_pc_inc   = r_pc + INSTR_BYTES;

  assign w_ld_mem = (r_state == FETCH) & w_ack
                  & ~stall_D & ~w_redirect;
  assign w_ld_buf = (r_state == BUF_FULL) & w_buf_vld
                  & ~stall_D & ~w_redirect;
  assign w_buf_ld = (r_state == FETCH) & w_ack & stall_D;

  fetch_skid_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_ld),
    .i_drain (w_ld_buf),
    .i_clear (w_redirect),
    .i_data  (imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_buf_vld),
    .o_data  (w_buf_data),
    .o_pc    (w_buf_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:     w_nxt = FETCH;
      FETCH: begin
        if (w_ack && stall_D)
          w_nxt = BUF_FULL;
        else if (w_redirect && r_req && !w_ack)
          w_nxt = DISCARD;
      end
      BUF_FULL: if (!stall_D) w_nxt = FETCH;
      DISCARD:  if (w_ack) w_nxt = FETCH;
      default:  w_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req_nxt = 1'b0;
    unique case (r_state)
      FETCH:   w_req_nxt = r_req ? ~w_ack : ~stall_F;
      DISCARD: w_req_nxt = ~w_ack;
      default: w_req_nxt = 1'b0;
    endcase

    w_pc_nxt = r_pc;
    unique case (1'b1)
      w_redirect:         w_pc_nxt = pc_branch_D;
      w_ld_mem, w_ld_buf: w_pc_nxt = w_pc_inc;
      default:            w_pc_nxt = r_pc;
    endcase

    // Anything not loaded or held becomes a bubble.
    w_ifid_nxt = if_id_t'{instr:    NOP_INSTR,
                          pc_plus4: r_ifid.pc_plus4,
                          valid:    1'b0};
    unique case (1'b1)
      w_redirect: ;
      stall_D:    w_ifid_nxt = r_ifid;
      w_ld_mem:
        w_ifid_nxt = if_id_t'{instr:    imem_rdata,
                              pc_plus4: w_pc_inc,
                              valid:    1'b1};
      w_ld_buf:
        w_ifid_nxt = if_id_t'{instr:    w_buf_data,
                              pc_plus4: w_buf_pc + INSTR_BYTES,
                              valid:    1'b1};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_old  <= RESET_PC;
      r_req  <= 1'b0;
      r_ifid <= if_id_t'{instr:    NOP_INSTR,
                         pc_plus4: '0,
                         valid:    1'b0};
    end else begin
      r_pc   <= w_pc_nxt;
      r_req  <= w_req_nxt;
      r_ifid <= w_ifid_nxt;
      if (r_state == FETCH && w_nxt == DISCARD)
        r_old <= r_pc;
    end
  end

  // The abandoned request keeps its address until memory answers.
  assign imem_addr  = (r_state == DISCARD) ? r_old : r_pc;
  assign imem_req   = r_req;
  assign pc_F       = r_pc;
  assign instr_D    = r_ifid.instr;
  assign pc_plus4_D = r_ifid.pc_plus4;
  assign valid_D    = r_ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and random bench for fetch_stage with a
// behavioural memory and instruction-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_F = 1'b0;
  logic        stall_D = 1'b0;
  logic        pc_src_D = 1'b0;
  logic [31:0] pc_branch_D = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_plus4_D;
  logic        valid_D;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .pc_src_D    (pc_src_D),
    .pc_branch_D (pc_branch_D),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_F        (pc_F),
    .instr_D     (instr_D),
    .pc_plus4_D  (pc_plus4_D),
    .valid_D     (valid_D)
  );

  int nchk = 0;
  int nerr = 0;

  logic        mem_en = 1'b1;
  int          mem_wait = 0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [31:0] exp_pc = '0;
  int          ndeliv = 0;

  logic        p_req, p_ack, p_stall, p_sf, p_src, p_rst, p_valid;
  logic [31:0] p_addr, p_tgt, p_instr, p_pp4;

  // Program image: word at address a holds (a/4)+0xA.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a >> 2) + 32'hA;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    if (p_req && !p_ack) begin
      check("req_hold", {31'b0, imem_req}, 32'd1);
      check("addr_hold", imem_addr, p_addr);
    end
    if (p_src && !p_stall) begin
      exp_pc = p_tgt;
      check("flush_valid", {31'b0, valid_D}, 32'd0);
      check("flush_instr", instr_D, NOP);
    end else if (p_stall) begin
      check("hold_valid", {31'b0, valid_D}, {31'b0, p_valid});
      check("hold_instr", instr_D, p_instr);
      check("hold_pp4", pc_plus4_D, p_pp4);
    end else if (valid_D === 1'b1) begin
      check("deliv_instr", instr_D, memf(exp_pc));
      check("deliv_pp4", pc_plus4_D, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      ndeliv++;
    end else begin
      check("bubble_instr", instr_D, NOP);
    end
    if (imem_req === 1'b1 && !(p_req && !p_ack)) begin
      check("new_req_addr", imem_addr, exp_pc);
      check("stallF_gate", {31'b0, p_sf}, 32'd0);
    end
  endtask

  // One clock: memory answers, edge, then model checks.
  task automatic cyc();
    if (mem_en) begin
      imem_ack = 1'b0;
      if (imem_req !== 1'b1) busy = 1'b0;
      else begin
        if (!busy) begin busy = 1'b1; cnt = mem_wait; end
        if (cnt == 0) begin
          imem_ack = 1'b1;
          imem_rdata = memf(imem_addr);
          busy = 1'b0;
        end else cnt--;
      end
    end
    p_req = imem_req;   p_ack = imem_ack;
    p_stall = stall_D;  p_sf = stall_F;
    p_src = pc_src_D;   p_tgt = pc_branch_D;
    p_rst = rst_n;      p_addr = imem_addr;
    p_valid = valid_D;  p_instr = instr_D;
    p_pp4 = pc_plus4_D;
    @(posedge clk);
    #1;
    if (rst_n && p_rst) model_check();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b0; busy = 1'b0; exp_pc = 32'h0;
    stall_D = 1'b0; stall_F = 1'b0; pc_src_D = 1'b0;
    mem_wait = 0; mem_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int maxc, input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < maxc) begin cyc(); n++; end
    check({tag, "_req_seen"}, {31'b0, imem_req}, 32'd1);
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    int n = 0;
    while (valid_D !== 1'b1 && n < maxc) begin cyc(); n++; end
    check({tag, "_valid_seen"}, {31'b0, valid_D}, 32'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc", pc_F, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, valid_D}, 32'd0);
    check("rst_instr", instr_D, NOP);
    check("rst_pp4", pc_plus4_D, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait stream
    cyc();
    check("idle_req", {31'b0, imem_req}, 32'd0);
    cyc();
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    cyc();
    check("A_instr", instr_D, 32'hA);
    check("A_pp4", pc_plus4_D, 32'h4);
    cyc();
    cyc();
    check("B_instr", instr_D, 32'hB);
    check("B_pp4", pc_plus4_D, 32'h8);

    // stall across the ack of C
    stall_D = 1'b1;
    repeat (3) cyc();
    check("stall_instr", instr_D, 32'hB);
    check("bufull_req", {31'b0, imem_req}, 32'd0);
    stall_D = 1'b0;
    cyc();
    check("C_instr", instr_D, 32'hC);
    check("C_pp4", pc_plus4_D, 32'hC);

    // redirect during a 2-wait request to 8
    do_reset();
    repeat (5) cyc();
    check("r35_B", instr_D, 32'hB);
    mem_wait = 2;
    cyc();
    check("r35_addr8", imem_addr, 32'h8);
    pc_src_D = 1'b1; pc_branch_D = 32'h100;
    cyc();
    pc_src_D = 1'b0;
    check("r35_flush", {31'b0, valid_D}, 32'd0);
    check("r35_pc", pc_F, 32'h100);
    check("r35_keep", imem_addr, 32'h8);
    cyc();
    check("r35_keep2", imem_addr, 32'h8);
    cyc();
    check("r35_drop", {31'b0, valid_D}, 32'd0);
    mem_wait = 0;
    wait_req(10, "r35");
    check("r35_new", imem_addr, 32'h100);
    wait_valid(10, "r35");
    check("r35_instr", instr_D, memf(32'h100));

    // redirect coincident with ack
    wait_req(10, "r36a");
    pc_src_D = 1'b1; pc_branch_D = 32'h200;
    cyc();
    pc_src_D = 1'b0;
    check("r36_flush", {31'b0, valid_D}, 32'd0);
    wait_req(10, "r36");
    check("r36_new", imem_addr, 32'h200);
    wait_valid(10, "r36");
    check("r36_instr", instr_D, memf(32'h200));

    // reset mid-request, then a late ack
    mem_wait = 2;
    wait_req(10, "r37a");
    rst_n = 1'b0;
    #1;
    check("r37_req", {31'b0, imem_req}, 32'd0);
    check("r37_pc", pc_F, 32'h0);
    busy = 1'b0; exp_pc = 32'h0; mem_en = 1'b0;
    mem_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    cyc();
    imem_ack = 1'b0; mem_en = 1'b1;
    check("r37_novalid", {31'b0, valid_D}, 32'd0);
    wait_valid(10, "r37");
    check("r37_instr", instr_D, 32'hA);
    check("r37_pp4", pc_plus4_D, 32'h4);

    // wrap at the top of the address space
    pc_src_D = 1'b1; pc_branch_D = 32'hFFFF_FFFC;
    cyc();
    pc_src_D = 1'b0;
    wait_valid(10, "r38");
    check("r38_pp4", pc_plus4_D, 32'h0);
    check("r38_instr", instr_D, memf(32'hFFFF_FFFC));
    wait_req(10, "r38");
    check("r38_addr", imem_addr, 32'h0);

    // random traffic against the model
    ndeliv = 0;
    for (int i = 0; i < 400; i++) begin
      stall_D     = ($urandom_range(0, 3) == 0);
      stall_F     = ($urandom_range(0, 4) == 0);
      pc_src_D    = ($urandom_range(0, 19) == 0);
      pc_branch_D = $urandom() & 32'hFFFF_FFFC;
      mem_wait    = $urandom_range(0, 3);
      cyc();
    end
    stall_D = 1'b0; stall_F = 1'b0; pc_src_D = 1'b0;
    check("liveness", {31'b0, (ndeliv > 20)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
